// File: rtl/multi_switch_requester.sv
// multi_switch_requester: round-robin egress requester for NUM_CH frame/sideband
// buffer pairs. Streams one whole frame at a time onto an AXI-Stream port,
// rewinds and retries a frame when the switch stalls too long, and drops it
// (skipping the buffer past it) once the retry budget is spent.
module multi_switch_requester #(
   parameter int NUM_CH            = 4,
   parameter int DATA_WIDTH        = 16,
   parameter int ADDR_WIDTH        = 11,
   parameter int DEST_WIDTH        = 4,
   parameter int TIMEOUT_CTR_WIDTH = 3,
   parameter int RETRY_LIMIT       = 2
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic [NUM_CH*(ADDR_WIDTH+1+DEST_WIDTH)-1:0]   sideband_rdata,
   input  logic [NUM_CH-1:0]                             sideband_empty,
   output logic [NUM_CH-1:0]                             sideband_ren,
   input  logic [NUM_CH*DATA_WIDTH-1:0]                  frame_rdata,
   input  logic [NUM_CH*(ADDR_WIDTH+1)-1:0]              frame_rptr,
   output logic [NUM_CH-1:0]                             frame_ren,
   output logic [NUM_CH-1:0]                             frame_rrst,
   output logic [ADDR_WIDTH:0]                           frame_rst_rptr,
   output logic [DATA_WIDTH-1:0]                         egress_tdata,
   output logic [DEST_WIDTH-1:0]                         egress_tdest,
   output logic                                          egress_tlast,
   output logic                                          egress_tvalid,
   input  logic                                          egress_tready,
   output logic [15:0]                                   frames_sent,
   output logic [15:0]                                   frames_dropped,
   output logic                                          busy
);

   localparam int PTR_W   = ADDR_WIDTH + 1;
   localparam int SB_W    = PTR_W + DEST_WIDTH;
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int RTY_W   = $clog2(RETRY_LIMIT + 1) + 1;
   localparam int STALL_W = TIMEOUT_CTR_WIDTH + 1;

   localparam logic [CH_W-1:0]  LAST_INIT = CH_W'(NUM_CH - 1);
   localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(RETRY_LIMIT);

   typedef enum logic [2:0] {IDLE, SB_WAIT, LOAD, SEND, REWIND} state_t;

   state_t              state;
   logic [CH_W-1:0]     grant;
   logic [CH_W-1:0]     last_served;
   logic                first_load;
   logic [PTR_W-1:0]    end_ptr;
   logic [PTR_W-1:0]    start_ptr;
   logic [RTY_W-1:0]    retry_cnt;
   logic [STALL_W-1:0]  stall_cnt;

   logic [SB_W-1:0]       sb_arr [NUM_CH];
   logic [DATA_WIDTH-1:0] fd_arr [NUM_CH];
   logic [PTR_W-1:0]      fp_arr [NUM_CH];

   logic [CH_W-1:0]       pick;
   logic [CH_W-1:0]       cand;
   logic                  pick_valid;
   logic [SB_W-1:0]       sb_sel;
   logic [PTR_W-1:0]      sb_end;
   logic [DEST_WIDTH-1:0] sb_dest;
   logic [PTR_W-1:0]      cur_rptr;
   logic [PTR_W-1:0]      next_rptr;
   logic [PTR_W-1:0]      cur_end;
   logic [DATA_WIDTH-1:0] cur_data;
   logic [NUM_CH-1:0]     grant_oh;
   logic                  handshake;
   logic                  load_word;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] c);
      logic [NUM_CH-1:0] r;
      r    = '0;
      r[c] = 1'b1;
      return r;
   endfunction

   for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
      assign sb_arr[g] = sideband_rdata[g*SB_W +: SB_W];
      assign fd_arr[g] = frame_rdata[g*DATA_WIDTH +: DATA_WIDTH];
      assign fp_arr[g] = frame_rptr[g*PTR_W +: PTR_W];
   end

   // Round-robin pick: nearest non-empty channel above last_served, wrapping,
   // with last_served itself tried last.
   always_comb begin
      pick       = '0;
      pick_valid = 1'b0;
      cand       = '0;
      for (int i = NUM_CH; i >= 1; i--) begin
         cand = CH_W'((int'(last_served) + i) % NUM_CH);
         if (!sideband_empty[cand]) begin
            pick       = cand;
            pick_valid = 1'b1;
         end
      end
   end

   assign sb_sel    = sb_arr[grant];
   assign sb_end    = sb_sel[SB_W-1:DEST_WIDTH];
   assign sb_dest   = sb_sel[DEST_WIDTH-1:0];
   assign cur_rptr  = fp_arr[grant];
   assign cur_data  = fd_arr[grant];
   assign next_rptr = cur_rptr + 1'b1;
   // Sideband data is only valid on the first LOAD; a retried LOAD uses the latched copy.
   assign cur_end   = first_load ? sb_end : end_ptr;
   assign grant_oh  = ch_onehot(grant);
   assign handshake = egress_tvalid & egress_tready;

   // The read pointer must advance in the same cycle the word is captured so the
   // next word is already presented when the following handshake arrives.
   assign load_word = !reset &&
                      (((state == LOAD) && (cur_rptr != cur_end)) ||
                       ((state == SEND) && handshake && !egress_tlast));
   assign frame_ren = load_word ? grant_oh : '0;
   assign busy      = (state != IDLE);

   // Request/stream/retry state machine with registered egress and buffer controls.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         grant          <= '0;
         last_served    <= LAST_INIT;
         first_load     <= 1'b0;
         end_ptr        <= '0;
         start_ptr      <= '0;
         retry_cnt      <= '0;
         stall_cnt      <= '0;
         sideband_ren   <= '0;
         frame_rrst     <= '0;
         frame_rst_rptr <= '0;
         egress_tdata   <= '0;
         egress_tdest   <= '0;
         egress_tlast   <= 1'b0;
         egress_tvalid  <= 1'b0;
         frames_sent    <= '0;
         frames_dropped <= '0;
      end else begin
         sideband_ren <= '0;
         frame_rrst   <= '0;
         case (state)
            IDLE: begin
               stall_cnt <= '0;
               if (pick_valid) begin
                  grant        <= pick;
                  sideband_ren <= ch_onehot(pick);
                  state        <= SB_WAIT;
               end
            end
            SB_WAIT: begin
               first_load <= 1'b1;
               state      <= LOAD;
            end
            LOAD: begin
               stall_cnt  <= '0;
               first_load <= 1'b0;
               if (first_load) begin
                  end_ptr   <= sb_end;
                  start_ptr <= cur_rptr;
                  retry_cnt <= '0;
               end
               if (cur_rptr == cur_end) begin
                  // Zero-length entry: consume it without touching the egress port.
                  frames_dropped <= sat_inc(frames_dropped);
                  last_served    <= grant;
                  state          <= IDLE;
               end else begin
                  if (first_load) begin
                     egress_tdest <= sb_dest;
                  end
                  egress_tdata  <= cur_data;
                  egress_tvalid <= 1'b1;
                  egress_tlast  <= (next_rptr == cur_end);
                  state         <= SEND;
               end
            end
            SEND: begin
               if (handshake) begin
                  stall_cnt <= '0;
                  if (egress_tlast) begin
                     frames_sent   <= sat_inc(frames_sent);
                     last_served   <= grant;
                     egress_tvalid <= 1'b0;
                     egress_tlast  <= 1'b0;
                     state         <= IDLE;
                  end else begin
                     egress_tdata <= cur_data;
                     egress_tlast <= (next_rptr == end_ptr);
                  end
               end else if (stall_cnt[STALL_W-1]) begin
                  // Switch timed out: drop tvalid without tlast so it discards the partial frame.
                  egress_tvalid <= 1'b0;
                  egress_tlast  <= 1'b0;
                  stall_cnt     <= '0;
                  frame_rrst    <= grant_oh;
                  if (retry_cnt < RETRY_MAX) begin
                     retry_cnt      <= retry_cnt + 1'b1;
                     frame_rst_rptr <= start_ptr;
                     state          <= REWIND;
                  end else begin
                     frame_rst_rptr <= end_ptr;
                     frames_dropped <= sat_inc(frames_dropped);
                     last_served    <= grant;
                     state          <= IDLE;
                  end
               end else begin
                  stall_cnt <= stall_cnt + 1'b1;
               end
            end
            REWIND: begin
               stall_cnt <= '0;
               state     <= LOAD;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multi_switch_requester.sv
// Bench for multi_switch_requester: models per-channel frame buffers and
// sideband FIFOs, scoreboards the egress stream against queued frames.
module tb_multi_switch_requester;

   localparam int NUM_CH = 4;
   localparam int DW     = 16;
   localparam int AW     = 11;
   localparam int DSTW   = 4;
   localparam int PW     = AW + 1;
   localparam int SBW    = PW + DSTW;

   logic                  clk;
   logic                  reset;
   logic [NUM_CH*SBW-1:0] sideband_rdata;
   logic [NUM_CH-1:0]     sideband_empty;
   logic [NUM_CH-1:0]     sideband_ren;
   logic [NUM_CH*DW-1:0]  frame_rdata;
   logic [NUM_CH*PW-1:0]  frame_rptr;
   logic [NUM_CH-1:0]     frame_ren;
   logic [NUM_CH-1:0]     frame_rrst;
   logic [PW-1:0]         frame_rst_rptr;
   logic [DW-1:0]         egress_tdata;
   logic [DSTW-1:0]       egress_tdest;
   logic                  egress_tlast;
   logic                  egress_tvalid;
   logic                  egress_tready;
   logic [15:0]           frames_sent;
   logic [15:0]           frames_dropped;
   logic                  busy;

   multi_switch_requester #(
      .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEST_WIDTH(DSTW),
      .TIMEOUT_CTR_WIDTH(3), .RETRY_LIMIT(2)
   ) dut (
      .clk(clk), .reset(reset),
      .sideband_rdata(sideband_rdata), .sideband_empty(sideband_empty), .sideband_ren(sideband_ren),
      .frame_rdata(frame_rdata), .frame_rptr(frame_rptr), .frame_ren(frame_ren),
      .frame_rrst(frame_rrst), .frame_rst_rptr(frame_rst_rptr),
      .egress_tdata(egress_tdata), .egress_tdest(egress_tdest), .egress_tlast(egress_tlast),
      .egress_tvalid(egress_tvalid), .egress_tready(egress_tready),
      .frames_sent(frames_sent), .frames_dropped(frames_dropped), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Buffer model state
   logic [DW-1:0]  mem [NUM_CH][4096];
   logic [PW-1:0]  ptr [NUM_CH];
   logic [PW-1:0]  wp [NUM_CH];
   logic [SBW-1:0] sb_mem [NUM_CH][64];
   logic [SBW-1:0] sb_out [NUM_CH];
   int             sb_wr [NUM_CH];
   int             sb_rd [NUM_CH];
   logic           tb_load;

   initial begin
      for (int c = 0; c < NUM_CH; c++) begin
         sb_wr[c] = 0;
         wp[c]    = '0;
      end
   end

   // Frame buffer read pointers: bench preload, rewind load, or advance.
   always @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (tb_load)            ptr[c] <= wp[c];
         else if (frame_rrst[c]) ptr[c] <= frame_rst_rptr;
         else if (frame_ren[c])  ptr[c] <= ptr[c] + 12'd1;
      end
   end

   // Sideband FIFOs: entry appears the cycle after the read pulse.
   always @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (sideband_ren[c]) begin
            sb_out[c] <= sb_mem[c][sb_rd[c]];
            sb_rd[c]  <= sb_rd[c] + 1;
         end
      end
   end

   initial begin
      for (int c = 0; c < NUM_CH; c++) sb_rd[c] = 0;
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         sideband_empty[c]            = (sb_rd[c] == sb_wr[c]);
         sideband_rdata[c*SBW +: SBW] = sb_out[c];
         frame_rdata[c*DW +: DW]      = mem[c][ptr[c]];
         frame_rptr[c*PW +: PW]       = ptr[c];
      end
   end

   // Scoreboard and observation logs
   logic [20:0] exp_q [$];
   logic [20:0] obs_q [$];
   logic [15:0] rrst_q [$];
   int          ren_cnt [NUM_CH];
   int          n_cmp, n_bad;
   int          cyc, first_tv, last_tv, tv_cycles, first_sbren, stab_err;
   int          mode;
   int          ser;
   logic        prev_stall;
   logic [20:0] prev_word;

   task automatic push_frame(input int ch, input int nw, input logic [DSTW-1:0] dest);
      logic [PW-1:0] a;
      a = wp[ch];
      for (int i = 0; i < nw; i++) begin
         mem[ch][a] = DW'(ch * 4096 + ser);
         exp_q.push_back({(i == nw - 1), dest, mem[ch][a]});
         a   = a + 12'd1;
         ser = ser + 1;
      end
      sb_mem[ch][sb_wr[ch]] = {a, dest};
      sb_wr[ch]             = sb_wr[ch] + 1;
      wp[ch]                = a;
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      tb_load       = 1'b1;
      egress_tready = (mode != 1);
      repeat (2) @(posedge clk);
      #1;
      reset   = 1'b0;
      tb_load = 1'b0;
      cyc = 0; first_tv = -1; last_tv = -1; tv_cycles = 0; first_sbren = -1; stab_err = 0;
      prev_stall = 1'b0; prev_word = '0;
      exp_q.delete(); obs_q.delete(); rrst_q.delete();
      for (int c = 0; c < NUM_CH; c++) ren_cnt[c] = 0;
   endtask

   // Advance one cycle, recording what the DUT did in it (sampled mid-cycle).
   task automatic step();
      @(negedge clk);
      cyc = cyc + 1;
      if (egress_tvalid) begin
         tv_cycles = tv_cycles + 1;
         if (first_tv < 0) first_tv = cyc;
         last_tv = cyc;
      end
      if (sideband_ren != '0 && first_sbren < 0) first_sbren = cyc;
      if (egress_tvalid && egress_tready) obs_q.push_back({egress_tlast, egress_tdest, egress_tdata});
      if (prev_stall && egress_tvalid && ({egress_tlast, egress_tdest, egress_tdata} !== prev_word))
         stab_err = stab_err + 1;
      prev_stall = egress_tvalid && !egress_tready;
      prev_word  = {egress_tlast, egress_tdest, egress_tdata};
      for (int c = 0; c < NUM_CH; c++) begin
         if (frame_ren[c])  ren_cnt[c] = ren_cnt[c] + 1;
         if (frame_rrst[c]) rrst_q.push_back({4'(c), frame_rst_rptr});
      end
      @(posedge clk);
      #1;
      if (mode == 2) egress_tready = ~egress_tready;
   endtask

   task automatic test_reset();
      mode = 0;
      do_reset();
      n_cmp++; if ({egress_tvalid, egress_tlast, busy} !== 3'b000) begin n_bad++;
         $display("FAIL reset_ctrl: got %b expected 000", {egress_tvalid, egress_tlast, busy}); end
      n_cmp++; if ({egress_tdata, egress_tdest} !== '0) begin n_bad++;
         $display("FAIL reset_data: got %h expected 0", {egress_tdata, egress_tdest}); end
      n_cmp++; if ({sideband_ren, frame_ren, frame_rrst, frame_rst_rptr} !== '0) begin n_bad++;
         $display("FAIL reset_bufctl: got %h expected 0", {sideband_ren, frame_ren, frame_rrst, frame_rst_rptr}); end
      n_cmp++; if ({frames_sent, frames_dropped} !== 32'd0) begin n_bad++;
         $display("FAIL reset_counters: got %h expected 0", {frames_sent, frames_dropped}); end
   endtask

   task automatic test_single_frame();
      logic [20:0] e, o;
      mode = 0;
      do_reset();
      push_frame(0, 4, 4'h5);
      repeat (12) step();
      n_cmp++; if (first_sbren !== 2) begin n_bad++;
         $display("FAIL single_sbren_cycle: got %0d expected 2", first_sbren); end
      n_cmp++; if (first_tv !== 4 || last_tv !== 7 || tv_cycles !== 4) begin n_bad++;
         $display("FAIL single_tvalid_window: got %0d..%0d (%0d) expected 4..7 (4)", first_tv, last_tv, tv_cycles); end
      n_cmp++; if (obs_q.size() !== 4) begin n_bad++;
         $display("FAIL single_count: got %0d expected 4", obs_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL single_word: got %h expected %h", o, e); end
      end
      n_cmp++; if (frames_sent !== 16'd1) begin n_bad++;
         $display("FAIL single_sent: got %0d expected 1", frames_sent); end
      n_cmp++; if (ren_cnt[0] !== 4) begin n_bad++;
         $display("FAIL single_ren: got %0d expected 4", ren_cnt[0]); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++;
         $display("FAIL single_busy_end: got %b expected 0", busy); end
   endtask

   task automatic test_round_robin();
      logic [20:0] e, o;
      mode = 0;
      do_reset();
      push_frame(0, 2, 4'h1);
      push_frame(2, 3, 4'h2);
      push_frame(0, 2, 4'h3);
      push_frame(2, 3, 4'h4);
      repeat (30) step();
      n_cmp++; if (obs_q.size() !== 10) begin n_bad++;
         $display("FAIL rr_count: got %0d expected 10", obs_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL rr_word: got %h expected %h", o, e); end
      end
      n_cmp++; if (frames_sent !== 16'd4) begin n_bad++;
         $display("FAIL rr_sent: got %0d expected 4", frames_sent); end
      n_cmp++; if (first_tv !== 4 || last_tv !== 22) begin n_bad++;
         $display("FAIL rr_gap_timing: got %0d..%0d expected 4..22", first_tv, last_tv); end
      n_cmp++; if (ren_cnt[0] !== 4 || ren_cnt[2] !== 6) begin n_bad++;
         $display("FAIL rr_ren: got %0d/%0d expected 4/6", ren_cnt[0], ren_cnt[2]); end
   endtask

   task automatic test_wrap();
      logic [20:0] e, o;
      mode  = 0;
      wp[1] = 12'hFFF;
      do_reset();
      push_frame(1, 3, 4'h6);
      repeat (12) step();
      n_cmp++; if (obs_q.size() !== 3) begin n_bad++;
         $display("FAIL wrap_count: got %0d expected 3", obs_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL wrap_word: got %h expected %h", o, e); end
      end
      n_cmp++; if (frames_sent !== 16'd1) begin n_bad++;
         $display("FAIL wrap_sent: got %0d expected 1", frames_sent); end
      n_cmp++; if (ptr[1] !== 12'd2 || ren_cnt[1] !== 3) begin n_bad++;
         $display("FAIL wrap_ptr: got ptr %0d ren %0d expected ptr 2 ren 3", ptr[1], ren_cnt[1]); end
   endtask

   task automatic test_timeout();
      logic [PW-1:0] s, e;
      mode = 1;
      do_reset();
      s = wp[3];
      push_frame(3, 2, 4'h7);
      e = wp[3];
      repeat (40) step();
      n_cmp++; if (obs_q.size() !== 0) begin n_bad++;
         $display("FAIL to_no_handshake: got %0d words expected 0", obs_q.size()); end
      n_cmp++; if (tv_cycles !== 27) begin n_bad++;
         $display("FAIL to_tvalid_cycles: got %0d expected 27", tv_cycles); end
      n_cmp++; if (rrst_q.size() !== 3) begin n_bad++;
         $display("FAIL to_rrst_count: got %0d expected 3", rrst_q.size()); end
      else begin
         n_cmp++; if (rrst_q[0] !== {4'd3, s} || rrst_q[1] !== {4'd3, s} || rrst_q[2] !== {4'd3, e}) begin n_bad++;
            $display("FAIL to_rrst_ptrs: got %h %h %h expected %h %h %h",
                     rrst_q[0], rrst_q[1], rrst_q[2], {4'd3, s}, {4'd3, s}, {4'd3, e}); end
      end
      n_cmp++; if (frames_dropped !== 16'd1 || frames_sent !== 16'd0) begin n_bad++;
         $display("FAIL to_counters: got sent %0d dropped %0d expected 0/1", frames_sent, frames_dropped); end
      n_cmp++; if (ren_cnt[3] !== 3 || ptr[3] !== e) begin n_bad++;
         $display("FAIL to_buffer: got ren %0d ptr %0d expected 3 / %0d", ren_cnt[3], ptr[3], e); end
   endtask

   task automatic test_tready_toggle();
      logic [20:0] e, o;
      mode = 2;
      do_reset();
      push_frame(0, 8, 4'h8);
      repeat (30) step();
      n_cmp++; if (obs_q.size() !== 8) begin n_bad++;
         $display("FAIL tog_count: got %0d expected 8", obs_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL tog_word: got %h expected %h", o, e); end
      end
      n_cmp++; if (stab_err !== 0) begin n_bad++;
         $display("FAIL tog_stable: got %0d changes during stall expected 0", stab_err); end
      n_cmp++; if (frames_sent !== 16'd1 || frames_dropped !== 16'd0 || rrst_q.size() !== 0) begin n_bad++;
         $display("FAIL tog_no_abort: got sent %0d dropped %0d rrst %0d expected 1/0/0",
                  frames_sent, frames_dropped, rrst_q.size()); end
   endtask

   task automatic test_zero_length();
      mode = 0;
      do_reset();
      push_frame(2, 0, 4'h9);
      repeat (10) step();
      n_cmp++; if (tv_cycles !== 0) begin n_bad++;
         $display("FAIL zl_tvalid: got %0d cycles expected 0", tv_cycles); end
      n_cmp++; if (frames_dropped !== 16'd1 || frames_sent !== 16'd0) begin n_bad++;
         $display("FAIL zl_counters: got sent %0d dropped %0d expected 0/1", frames_sent, frames_dropped); end
      n_cmp++; if (first_sbren !== 2 || ren_cnt[2] !== 0 || busy !== 1'b0) begin n_bad++;
         $display("FAIL zl_sideband: got sbren %0d ren %0d busy %b expected 2/0/0", first_sbren, ren_cnt[2], busy); end
   endtask

   task automatic test_reset_mid_frame();
      mode = 1;
      do_reset();
      push_frame(0, 4, 4'hA);
      repeat (6) step();
      n_cmp++; if (egress_tvalid !== 1'b1 || busy !== 1'b1) begin n_bad++;
         $display("FAIL mid_active: got tvalid %b busy %b expected 1/1", egress_tvalid, busy); end
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++; if ({egress_tvalid, egress_tlast, busy, egress_tdata, egress_tdest} !== '0) begin n_bad++;
         $display("FAIL mid_egress: got %h expected 0", {egress_tvalid, egress_tlast, busy, egress_tdata, egress_tdest}); end
      n_cmp++; if ({sideband_ren, frame_ren, frame_rrst, frames_sent, frames_dropped} !== '0) begin n_bad++;
         $display("FAIL mid_ctl: got %h expected 0", {sideband_ren, frame_ren, frame_rrst, frames_sent, frames_dropped}); end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; tb_load = 1'b0; egress_tready = 1'b1;
      n_cmp = 0; n_bad = 0; ser = 1; mode = 0;
      test_reset();
      test_single_frame();
      test_round_robin();
      test_wrap();
      test_timeout();
      test_tready_toggle();
      test_zero_length();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multi_switch_requester.md
# multi_switch_requester

Multi-channel successor to the single-channel egress requester. Arbitrates round-robin among NUM_CH frame/sideband buffer pairs and streams one complete frame at a time onto a single AXI-Stream egress port toward the switch. On a switch-side timeout it rewinds and retries the frame up to RETRY_LIMIT times, then drops it and skips the frame buffer past it. Saturating sent/dropped counters are exported for CSR readout.

## Interface
- NUM_CH, 4: input channels (1..8)
- DATA_WIDTH, 16: frame word / tdata width
- ADDR_WIDTH, 11: frame buffer address bits; pointers are ADDR_WIDTH+1 bits (wrap bit)
- DEST_WIDTH, 4: tdest width
- TIMEOUT_CTR_WIDTH, 3: stall timeout = 2^TIMEOUT_CTR_WIDTH consecutive stalled cycles
- RETRY_LIMIT, 2: retries before drop (0 = drop on first timeout)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- sideband_rdata  in  NUM_CH*(ADDR_WIDTH+1+DEST_WIDTH)  per channel {end_ptr, dest}; valid the cycle after sideband_ren
- sideband_empty  in  NUM_CH  per-channel sideband FIFO empty
- sideband_ren  out  NUM_CH  one-hot read pulse
- frame_rdata  in  NUM_CH*DATA_WIDTH  per-channel word at current read pointer (first-word-fall-through)
- frame_rptr  in  NUM_CH*(ADDR_WIDTH+1)  per-channel current read pointer
- frame_ren  out  NUM_CH  one-hot; advances that channel's read pointer next cycle
- frame_rrst  out  NUM_CH  one-hot pulse; channel loads read pointer from frame_rst_rptr next cycle
- frame_rst_rptr  out  ADDR_WIDTH+1  pointer to load; valid while any frame_rrst is high
- egress_tdata / tdest / tlast / tvalid  out  DATA_WIDTH / DEST_WIDTH / 1 / 1  AXI-Stream source
- egress_tready  in  1  AXI-Stream sink ready
- frames_sent  out  16  saturating count of frames completed with tlast handshake
- frames_dropped  out  16  saturating count of dropped (retry-exhausted or zero-length) frames
- busy  out  1  high in any state but IDLE

## Operation
- States: IDLE, SB_WAIT, LOAD, SEND, REWIND.
- IDLE: grant = first non-empty channel searching upward from (last_served+1) mod NUM_CH; register grant, pulse sideband_ren[grant] next cycle, go SB_WAIT. last_served resets to NUM_CH-1 (ch0 wins first).
- SB_WAIT: one cycle; go LOAD.
- LOAD (first entry): latch end_ptr, dest, start_ptr = frame_rptr[grant], retry_cnt = 0. If start_ptr == end_ptr: zero-length frame, frames_dropped++, last_served = grant, go IDLE, no egress activity. Else load output register with frame_rdata[grant], pulse frame_ren[grant], tlast = (start_ptr+1 == end_ptr), go SEND. LOAD after REWIND keeps retry_cnt.
- SEND: on handshake (tvalid & tready) with tlast=0, load next word, pulse frame_ren, tlast = (frame_rptr+1 == end_ptr); one word/cycle at full throughput. On handshake with tlast=1: frames_sent++, last_served = grant, tvalid=0, go IDLE.
- Pointer arithmetic modulo 2^(ADDR_WIDTH+1); frame may wrap the buffer.
- Stall counter: cleared in IDLE/LOAD/REWIND and on every handshake; increments each cycle tvalid & ~tready. When its MSB sets: abort (tvalid low next cycle, no tlast; switch discards the partial frame).
  - retry_cnt < RETRY_LIMIT: retry_cnt++, frame_rrst[grant] with frame_rst_rptr = start_ptr, go REWIND.
  - else: frame_rrst[grant] with frame_rst_rptr = end_ptr, frames_dropped++, last_served = grant, go IDLE.
- REWIND: one cycle for the buffer to apply the pointer; go LOAD.
- tdata/tdest/tlast are held stable while tvalid & ~tready. tdest constant for the whole frame.
- Counters saturate at 16'hFFFF.

## Timing
- Reset: all outputs 0 (tvalid, tlast, tdata, tdest, ren/rrst vectors, frame_rst_rptr, counters, busy); state IDLE; reset mid-frame aborts with no tlast and no counter update.
- Sideband non-empty sampled in IDLE at cycle n: sideband_ren at n+1, LOAD at n+2, tvalid high at n+3.
- Frame end to next frame: tlast handshake at cycle m, next channel's tvalid no earlier than m+4.
- frame_ren pulses in the same cycle the output register loads, exactly once per word per attempt.
- sideband_empty changing while not in IDLE is ignored.
- Timeout: abort in the cycle after the 2^TIMEOUT_CTR_WIDTH-th stalled cycle; a handshake in that same cycle wins (no abort).

## Test plan
- Single 4-word frame on ch0, tready always 1 -> tvalid n+3..n+6, tlast only on word 4, frames_sent=1, exactly 4 frame_ren[0] pulses.
- ch0, ch2 each with 2 frames queued, tready=1 -> service order ch0, ch2, ch0, ch2; frames_sent=4.
- 3-word frame starting at pointer 2^(ADDR_WIDTH+1)-1 (wrap) -> 3 words, tlast on third, end pointer check correct.
- tready held low, TIMEOUT_CTR_WIDTH=3, RETRY_LIMIT=2 -> three attempts, each aborted after 8 stalled cycles, two rrst to start_ptr, final rrst to end_ptr, frames_dropped=1, frames_sent=0.
- tready toggled 1/0 every cycle on an 8-word frame -> tdata stable across every stall, no abort, words in order.
- Zero-length sideband entry (end_ptr == frame_rptr) -> no tvalid, frames_dropped=1; reset asserted mid-frame -> all outputs 0 next cycle.
